mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
//  Memory controller between the byte-wide RAM/IO port and the core.
//  Serves instruction fetches for icache/Fetcher and loads/stores for LSB.
//  Assembles little-endian bytes into mem_inst/mem_data and serialises store bytes.
//  Drives mem_inst_ready/mem_inst/mem_inst_addr/mem_busy, the fill interface that icache consumes.
// PARAMETERS
//  (none; widths from `XLEN=32 and constants in global_params.v)
// PORTS
//  clk             in   1      clock
//  rst             in   1      reset: synchronous, active-high
//  rdy             in   1      global enable; low = freeze all state, mem_wr=0
//  flush           in   1      mispredict flush
//  stall           in   1      pipeline stall; blocks ready pulses only
//  fet_mem_enable  in   1      fetch request; sampled only in IDLE
//  fet_pc          in   32     fetch address, halfword aligned
//  lsb_mem_enable  in   1      load/store request; sampled only in IDLE
//  lsb_mem_wr      in   1      1=store, 0=load
//  lsb_mem_len     in   2      0=byte, 1=half, 2=word
//  lsb_mem_signed  in   1      sign-extend loads
//  lsb_mem_addr    in   32     data address
//  lsb_mem_data    in   32     store data, low bytes used
//  io_buffer_full  in   1      IO write FIFO full
//  mem_din         in   8      RAM read byte; valid one cycle after address
//  mem_dout        out  8      RAM write byte
//  mem_a           out  32     RAM byte address
//  mem_wr          out  1      1=write cycle
//  mem_busy        out  1      state != IDLE
//  mem_inst_ready  out  1      1-cycle pulse: mem_inst valid
//  mem_inst        out  32     fetched word, bytes {A+3,A+2,A+1,A}
//  mem_inst_addr   out  32     address of mem_inst
//  mem_data_ready  out  1      1-cycle pulse: load data valid or store done
//  mem_data        out  32     extended load result
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0, including mem_a, mem_wr, mem_dout, both ready pulses and both data regs.
//  - States: IDLE, IFETCH, LOAD, STORE, DONE.
//  - IDLE arbitration: LSB wins over fetch when both requests are present. Acceptance edge = e0.
//  - Read of n bytes at A:
//    - cycle k+1 (k=0..n-1): mem_a=A+k.
//    - mem_din carries byte k in cycle k+2 and is captured at the end of that cycle.
//    - ready pulses in cycle n+2. Word read: ready in cycle 6 after the request cycle.
//  - Store of n bytes: cycle k+1 drives mem_a=A+k, mem_wr=1, mem_dout=data[8k+7:8k]. mem_data_ready pulses in cycle n+1.
//  - IO store (A[17:16]==2'b11): while io_buffer_full=1, hold the byte with mem_wr=0. Resume when it clears.
//  - Byte counter: 2 bits, no wrap past len. Address is 32-bit add, wrapping mod 2^32.
//  - Load extension: byte/half zero- or sign-extended per lsb_mem_signed. Word is passed as-is.
//  - IFETCH always reads 4 bytes (see CONFIGURATION).
//  - flush in IFETCH or LOAD: abort, no pulse, go to IDLE next cycle, mem_wr=0.
//  - flush in STORE: ignored. The store completes and pulses ready.
//  - flush in DONE: discard fetch/load result. A completed store still reports.
//  - Completion with stall=1: enter DONE and hold the result. Pulse in the first cycle with stall=0, then IDLE.
//  - mem_busy stays 1 during DONE.
//  - Requests are never accepted in the same cycle a ready pulse is asserted.
//  - rst mid-transaction: abort immediately, no pulse, mem_wr=0 the next cycle.
//  - rdy=0: no state change, mem_wr forced 0. The RAM read pipeline is treated as restarted, so the current byte is re-addressed on resume.
// CONFIGURATION
//  - MEM_CTRL_IFETCH_SHORT_EN defined:
//    - After byte0 is captured with byte0[1:0]!=2'b11, IFETCH stops after byte1.
//    - mem_inst={16'b0,b1,b0}, ready in cycle 4.
//    - Any extra address already issued is discarded.
//  - Undefined: IFETCH always reads 4 bytes.
// STRUCTURE
//  - global_params.v gets: state encodings, length codes LEN_B/LEN_H/LEN_W, IO_ADDR_HI=2'b11.
//  - Single module. Optional sub-module mem_ctrl_extend holds the combinational load extension.
// TESTING
//  - Word fetch: fet_pc=0x100 with RAM 13 05 10 00 -> mem_inst=0x00100513, addr 0x100, pulse in cycle 6.
//  - Short fetch (macro on): pc=0x104, RAM 01 45 -> mem_inst=0x00004501, pulse in cycle 4. Macro off: full word.
//  - Collision: LSB load plus fetch in the same cycle -> load served first, fetch accepted after the pulse.
//  - Signed byte load: RAM 0x80 -> mem_data=0xFFFFFF80. Unsigned -> 0x00000080.
//  - IO store: addr 0x30000, data 0x41, io_buffer_full=1 for 3 cycles -> mem_wr low 3 cycles, then a single write.
//  - Flush: flush in cycle 3 of an IFETCH -> no mem_inst_ready, IDLE next cycle. Flush during a word store -> all 4 bytes written, pulse.
//  - Stall: stall high at completion for 2 cycles -> pulse delayed 2 cycles, data unchanged.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide memory controller.
package mem_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [1:0] LEN_B      = 2'd0;
  localparam logic [1:0] LEN_H      = 2'd1;
  localparam logic [1:0] LEN_W      = 2'd2;
  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IFETCH,
    ST_LOAD,
    ST_STORE,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    KIND_FETCH,
    KIND_LOAD,
    KIND_STORE
  } kind_t;

  // Request latched at acceptance; the RAM port then runs from this copy.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [1:0]      len;
    logic            sign;
    kind_t           kind;
  } req_t;

  // Index of the final byte for a length code.
  function automatic logic [1:0] last_idx(input logic [1:0] len);
    case (len)
      LEN_B:   last_idx = 2'd0;
      LEN_H:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction

  function automatic logic is_io(input logic [XLEN-1:0] addr);
    is_io = (addr[17:16] == IO_ADDR_HI);
  endfunction

endpackage

// File: rtl/mem_ctrl_extend.sv
// Zero/sign extension of an assembled little-endian load value.
module mem_ctrl_extend
  import mem_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [1:0]      len,
  input  logic            sign,
  output logic [XLEN-1:0] result_c
);

  always_comb begin
    result_c = raw;
    case (len)
      LEN_B:   result_c = {{(XLEN-8){sign & raw[7]}}, raw[7:0]};
      LEN_H:   result_c = {{(XLEN-16){sign & raw[15]}}, raw[15:0]};
      default: result_c = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO controller serving instruction fetches and LSB loads/stores.
// Optional MEM_CTRL_IFETCH_SHORT_EN: stop a fetch after two bytes for compressed instructions.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic                stall,
  input  logic                fet_mem_enable,
  input  logic [XLEN-1:0]     fet_pc,
  input  logic                lsb_mem_enable,
  input  logic                lsb_mem_wr,
  input  logic [1:0]          lsb_mem_len,
  input  logic                lsb_mem_signed,
  input  logic [XLEN-1:0]     lsb_mem_addr,
  input  logic [XLEN-1:0]     lsb_mem_data,
  input  logic                io_buffer_full,
  input  logic [BYTE_W-1:0]   mem_din,
  output logic [BYTE_W-1:0]   mem_dout,
  output logic [XLEN-1:0]     mem_a,
  output logic                mem_wr,
  output logic                mem_busy,
  output logic                mem_inst_ready,
  output logic [XLEN-1:0]     mem_inst,
  output logic [XLEN-1:0]     mem_inst_addr,
  output logic                mem_data_ready,
  output logic [XLEN-1:0]     mem_data
);

  state_t          state, state_nx;
  req_t            req;
  logic [1:0]      last;
  logic [1:0]      iss_idx, iss_nx;
  logic [1:0]      cap_idx;
  logic [1:0]      st_idx, st_nx;
  logic            iss_v, cap_v, wr_q;
  logic            accept, rd_done, st_done, st_hold;
  logic [XLEN-1:0] asm_q, asm_c, ext_c;

  assign accept  = (state == ST_IDLE) && !flush && (lsb_mem_enable || fet_mem_enable);
  assign rd_done = cap_v && (cap_idx == last);
  assign st_done = wr_q && (st_idx == last);
  assign st_hold = is_io(req.addr) && io_buffer_full;
  assign iss_nx  = iss_idx + 2'd1;
  assign st_nx   = st_idx + 2'd1;

  // Word being assembled including the byte arriving this cycle.
  always_comb begin
    asm_c = asm_q;
    asm_c[{cap_idx, 3'b000} +: 8] = mem_din;
  end

  mem_ctrl_extend u_extend (
    .raw      (asm_c),
    .len      (req.len),
    .sign     (req.sign),
    .result_c (ext_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (rdy) begin
      case (state)
        ST_IDLE: begin
          if (accept)
            state_nx = lsb_mem_enable ? (lsb_mem_wr ? ST_STORE : ST_LOAD) : ST_IFETCH;
        end
        ST_IFETCH, ST_LOAD: begin
          if (flush)        state_nx = ST_IDLE;
          else if (rd_done) state_nx = ST_DONE;
        end
        ST_STORE: begin
          if (st_done) state_nx = ST_DONE;
        end
        ST_DONE: begin
          // A finished store still reports through a flush; reads are dropped.
          if (!stall || (flush && req.kind != KIND_STORE)) state_nx = ST_IDLE;
        end
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_busy       = 1'b0;
    mem_wr         = 1'b0;
    mem_inst_ready = 1'b0;
    mem_data_ready = 1'b0;
    mem_busy       = (state != ST_IDLE);
    mem_wr         = wr_q && rdy;
    if (state == ST_DONE && rdy && !stall) begin
      case (req.kind)
        KIND_FETCH: mem_inst_ready = !flush;
        KIND_LOAD:  mem_data_ready = !flush;
        default:    mem_data_ready = 1'b1;
      endcase
    end
  end

  // Address/byte sequencing and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      req           <= '0;
      last          <= '0;
      iss_idx       <= '0;
      cap_idx       <= '0;
      st_idx        <= '0;
      iss_v         <= 1'b0;
      cap_v         <= 1'b0;
      wr_q          <= 1'b0;
      asm_q         <= '0;
      mem_a         <= '0;
      mem_dout      <= '0;
      mem_inst      <= '0;
      mem_inst_addr <= '0;
      mem_data      <= '0;
    end else if (!rdy) begin
      // RAM read pipeline restarts: re-address the byte that was in flight.
      if ((state == ST_IFETCH || state == ST_LOAD) && cap_v) begin
        iss_idx <= cap_idx;
        iss_v   <= 1'b1;
        cap_v   <= 1'b0;
        mem_a   <= req.addr + XLEN'(cap_idx);
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            asm_q   <= '0;
            iss_idx <= '0;
            cap_v   <= 1'b0;
            st_idx  <= '0;
            if (lsb_mem_enable) begin
              req.addr <= lsb_mem_addr;
              req.data <= lsb_mem_data;
              req.len  <= lsb_mem_len;
              req.sign <= lsb_mem_signed;
              req.kind <= lsb_mem_wr ? KIND_STORE : KIND_LOAD;
              last     <= last_idx(lsb_mem_len);
              mem_a    <= lsb_mem_addr;
              mem_dout <= lsb_mem_data[7:0];
              iss_v    <= !lsb_mem_wr;
              wr_q     <= lsb_mem_wr && !(is_io(lsb_mem_addr) && io_buffer_full);
            end else begin
              req.addr <= fet_pc;
              req.data <= '0;
              req.len  <= LEN_W;
              req.sign <= 1'b0;
              req.kind <= KIND_FETCH;
              last     <= 2'd3;
              mem_a    <= fet_pc;
              iss_v    <= 1'b1;
              wr_q     <= 1'b0;
            end
          end
        end
        ST_IFETCH, ST_LOAD: begin
          if (flush || rd_done) begin
            iss_v <= 1'b0;
            cap_v <= 1'b0;
            if (!flush) begin
              if (req.kind == KIND_FETCH) begin
                mem_inst      <= asm_c;
                mem_inst_addr <= req.addr;
              end else begin
                mem_data <= ext_c;
              end
            end
          end else begin
            if (cap_v) asm_q <= asm_c;
            cap_v   <= iss_v;
            cap_idx <= iss_idx;
            if (iss_v && iss_idx != last) begin
              iss_idx <= iss_nx;
              mem_a   <= req.addr + XLEN'(iss_nx);
            end else begin
              iss_v <= 1'b0;
            end
`ifdef MEM_CTRL_IFETCH_SHORT_EN
            // Compressed encoding: only two bytes belong to this instruction.
            if (state == ST_IFETCH && cap_v && cap_idx == 2'd0 && mem_din[1:0] != 2'b11)
              last <= 2'd1;
`endif
          end
        end
        ST_STORE: begin
          if (wr_q) begin
            if (st_idx == last) begin
              wr_q <= 1'b0;
            end else begin
              st_idx   <= st_nx;
              mem_a    <= req.addr + XLEN'(st_nx);
              mem_dout <= req.data[{st_nx, 3'b000} +: 8];
              wr_q     <= !st_hold;
            end
          end else begin
            wr_q <= !st_hold;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
